instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential RV32I instruction encoder and program writer, the inverse of the control unit's decode path. It accepts symbolic instruction requests (operation, register indices, immediate) over a valid/ready handshake and packs each one into a 32-bit machine word. It buffers encoded words in a small FIFO and streams them into instruction memory at consecutive word addresses. It is used by test harnesses and the boot loader to build programs that the CPU then fetches and decodes.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2
- `ADDR_WIDTH`, 32: memory address width
- `BASE_ADDR`, 0: first write address after reset
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 1: request present
- `req_ready` out 1: encoder can accept
- `req_op` in 4: operation code, `enc_op_t`
- `req_rd`, `req_rs1`, `req_rs2` in 5 each: register indices
- `req_imm` in 32: signed immediate; LUI uses `req_imm[19:0]`
- `mem_we` out 1: write request to instruction memory
- `mem_addr` out ADDR_WIDTH: write address
- `mem_wdata` out 32: encoded word
- `mem_ready` in 1: memory accepts the current write
- `err` out 1: one-cycle pulse, request rejected
- `count` out $clog2(DEPTH)+1: FIFO occupancy

## Operation
- Op encoding:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
  - 10 ADDI, 11 LUI, 12 SW, 13 BEQ, 14 BNE, 15 reserved
- Encoding formats:
  - R-type: opcode 0110011. SUB/SRA use funct7 0100000; all other R-type ops use 0000000.
  - ADDI: opcode 0010011. LUI: opcode 0110111. SW: opcode 0100011, funct3 010.
  - BEQ/BNE: opcode 1100011, funct3 000/001, standard B-immediate scatter.
- Immediate range checks:
  - ADDI/SW: `req_imm` must lie in [-2048, 2047].
  - BEQ/BNE: `req_imm` must lie in [-4096, 4094] with bit 0 = 0.
  - LUI: no range check.
  - Unused fields (e.g. rs2 for ADDI) are ignored and not encoded.
- Accept: a request is accepted on a cycle where `req_valid && req_ready`.
  - Legal request: the encoded word is pushed into the FIFO.
  - Reserved op or out-of-range immediate: request is consumed, nothing is pushed, and `err` is high the next cycle.
- `req_ready = (count != DEPTH)`. Push is refused when full even if a pop occurs in the same cycle.
- Write side:
  - `mem_we = (count != 0)`; `mem_wdata` = FIFO head.
  - Pop and `mem_addr += 4` on `mem_we && mem_ready`.
  - `mem_addr` wraps modulo 2^ADDR_WIDTH.
- Push and pop in the same cycle: `count` is unchanged and order is preserved.

## Timing
- Reset values: `req_ready`=1, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0, `err`=0, `count`=0.
- Latency: a request accepted at edge N into an empty FIFO gives `mem_we`=1 with its word from edge N onward, i.e. visible in cycle N+1.
- Throughput: one word per cycle with `mem_ready` held high.
- `mem_we`, `mem_addr` and `mem_wdata` stay stable while `mem_ready`=0.
- Reset asserted mid-stream discards all FIFO contents and restores the reset values on the next edge.

## Configuration
- `INSTR_ENC_BTYPE_EN` defined: BEQ/BNE are encoded as specified.
- `INSTR_ENC_BTYPE_EN` undefined: ops 13/14 are treated as reserved (consumed, `err` pulse) and the B-type packing logic is absent.

## Structure
- Package `instr_enc_pkg` holds:
  - `enc_op_t`
  - opcode constants (OP_R, OP_IMM, OP_LUI, OP_STORE, OP_BRANCH)
  - funct3/funct7 constants, shared with the control unit
- Sub-module `instr_fifo`: synchronous FIFO, width 32, depth DEPTH, with push/pop/count outputs.

## Test plan
- ADDI rd=1, rs1=0, imm=5 after reset → `mem_addr`=BASE_ADDR, `mem_wdata`=0x00500093, `mem_we` high the cycle after accept.
- ADD x3,x1,x2 then SUB x3,x1,x2, `mem_ready`=1 → words 0x002081B3 at addr 0 and 0x402081B3 at addr 4.
- SW rs2=2, rs1=1, imm=8 → 0x0020A423. LUI rd=5, imm=0x12345 → 0x123452B7.
- BNE rs1=1, rs2=2, imm=-8 → 0xFE209CE3 with the macro defined. Without the macro → `err` pulse and no write. ADDI imm=2048 → `err` pulse, `count` unchanged.
- `mem_ready`=0, push DEPTH requests → `req_ready` drops at count=DEPTH, outputs stay stable. Release `mem_ready` → DEPTH writes in order at consecutive addresses.
- BASE_ADDR=0xFFFFFFFC with two writes → addresses 0xFFFFFFFC then 0x0. Assert `rst` with 2 words queued → `count`=0, `mem_we`=0, `mem_addr`=BASE_ADDR next cycle.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// RV32I encoding constants and the symbolic op type, shared by the instruction
// encoder and the control unit decode path.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub,
    OpXor,
    OpOr,
    OpAnd,
    OpSll,
    OpSrl,
    OpSra,
    OpSlt,
    OpSltu,
    OpAddi,
    OpLui,
    OpSw,
    OpBeq,
    OpBne,
    OpRsvd
  } enc_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic [2:0] r_funct3(enc_op_t op);
    case (op)
      OpAdd, OpSub: return F3_ADD_SUB;
      OpSll:        return F3_SLL;
      OpSlt:        return F3_SLT;
      OpSltu:       return F3_SLTU;
      OpXor:        return F3_XOR;
      OpSrl, OpSra: return F3_SR;
      OpOr:         return F3_OR;
      OpAnd:        return F3_AND;
      default:      return F3_ADD_SUB;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus of the instruction encoder.
// master = requester/memory side, slave = encoder.
interface instr_encoder_if #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32
);
  import instr_enc_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  enc_op_t                 req_op;
  logic [4:0]              req_rd;
  logic [4:0]              req_rs1;
  logic [4:0]              req_rs2;
  logic [31:0]             req_imm;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [31:0]             mem_wdata;
  logic                    mem_ready;
  logic                    err;
  logic [$clog2(DEPTH):0]  count;

  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, mem_ready,
    input  req_ready, mem_we, mem_addr, mem_wdata, err, count
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, mem_ready,
    output req_ready, mem_we, mem_addr, mem_wdata, err, count
  );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO for encoded words; push is ignored when full, pop when empty.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; readers gate the head with empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder and program writer: packs symbolic requests into machine
// words and streams them to instruction memory. INSTR_ENC_BTYPE_EN enables BEQ/BNE.
module instr_encoder #(
  parameter int unsigned           DEPTH      = 4,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);
  import instr_enc_pkg::*;

  enc_op_t               op;
  logic [31:0]           imm;
  logic [31:0]           word;
  logic [31:0]           head;
  logic                  legal, accept, push, pop, full, empty;
  logic                  imm_fits12;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  assign op         = bus.req_op;
  assign imm        = bus.req_imm;
  assign imm_fits12 = (imm[31:11] == {21{imm[11]}});

`ifdef INSTR_ENC_BTYPE_EN
  logic imm_fits13;
  // [-4096, 4094] and halfword aligned.
  assign imm_fits13 = (imm[31:12] == {20{imm[12]}}) && !imm[0];
`endif

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op)
      OpAdd, OpSub, OpXor, OpOr, OpAnd, OpSll, OpSrl, OpSra, OpSlt, OpSltu: begin
        word = {((op == OpSub) || (op == OpSra)) ? F7_ALT : F7_BASE,
                bus.req_rs2, bus.req_rs1, r_funct3(op), bus.req_rd, OP_R};
      end
      OpAddi: begin
        legal = imm_fits12;
        word  = {imm[11:0], bus.req_rs1, F3_ADD_SUB, bus.req_rd, OP_IMM};
      end
      OpLui: begin
        word = {imm[19:0], bus.req_rd, OP_LUI};
      end
      OpSw: begin
        legal = imm_fits12;
        word  = {imm[11:5], bus.req_rs2, bus.req_rs1, F3_SW, imm[4:0], OP_STORE};
      end
`ifdef INSTR_ENC_BTYPE_EN
      OpBeq, OpBne: begin
        legal = imm_fits13;
        word  = {imm[12], imm[10:5], bus.req_rs2, bus.req_rs1,
                 (op == OpBne) ? F3_BNE : F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
      end
`endif
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  assign bus.req_ready = !full;
  assign accept        = bus.req_valid && !full;
  assign push          = accept && legal;
  assign pop           = !empty && bus.mem_ready;

  instr_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(word),
    .pop  (pop),
    .rdata(head),
    .count(bus.count),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept && !legal;
      if (pop) addr_q <= addr_q + ADDR_WIDTH'(4);
    end
  end

  assign bus.mem_we    = !empty;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = empty ? 32'h0 : head;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: scoreboard of expected memory writes plus
// per-scenario checks of handshake, error pulse, occupancy, reset and address wrap.
module tb_instr_encoder;
  import instr_enc_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [63:0] sb[$];
  logic [31:0] push_addr = 32'h0;

  instr_encoder_if #(.DEPTH(DEPTH), .ADDR_WIDTH(32)) bus ();
  instr_encoder_if #(.DEPTH(DEPTH), .ADDR_WIDTH(32)) wbus ();

  instr_encoder #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  instr_encoder #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .BASE_ADDR(32'hFFFF_FFFC)) dut_w (
    .clk(clk),
    .rst(rst),
    .bus(wbus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: every write the memory accepts must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && bus.mem_we && bus.mem_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL write_unexpected: got addr %h data %h, required no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [63:0] exp;
        exp = sb.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== exp) begin
          miscompares++;
          $display("FAIL write: got addr %h data %h, required addr %h data %h",
                   bus.mem_addr, bus.mem_wdata, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  task automatic send(input enc_op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic legal,
                      input logic [31:0] word);
    int unsigned waited = 0;
    bus.req_op    = op;
    bus.req_rd    = rd;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_imm   = imm;
    bus.req_valid = 1'b1;
    @(negedge clk);
    while (!bus.req_ready) begin
      if (waited++ > 50) begin
        miscompares++;
        $display("FAIL req_ready_timeout: got req_ready 0 for 50 cycles, required 1");
        bus.req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (legal) begin
      sb.push_back({push_addr, word});
      push_addr += 32'd4;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int unsigned n = 0;
    while (bus.count != 0 || sb.size() != 0) begin
      if (n++ > 40) begin
        miscompares++;
        $display("FAIL drain_timeout: got count %0d pending %0d, required 0 0",
                 bus.count, sb.size());
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors += 7;
    if (bus.req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_req_ready: got %b required 1", bus.req_ready);
    end
    if (bus.mem_we !== 1'b0) begin
      miscompares++; $display("FAIL reset_mem_we: got %b required 0", bus.mem_we);
    end
    if (bus.mem_addr !== 32'h0) begin
      miscompares++; $display("FAIL reset_mem_addr: got %h required 0", bus.mem_addr);
    end
    if (bus.mem_wdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_mem_wdata: got %h required 0", bus.mem_wdata);
    end
    if (bus.err !== 1'b0) begin
      miscompares++; $display("FAIL reset_err: got %b required 0", bus.err);
    end
    if (bus.count !== 3'd0) begin
      miscompares++; $display("FAIL reset_count: got %0d required 0", bus.count);
    end
    if (wbus.mem_addr !== 32'hFFFF_FFFC) begin
      miscompares++; $display("FAIL reset_base_addr: got %h required fffffffc", wbus.mem_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_addi_latency();
    bus.mem_ready = 1'b1;
    send(OpAddi, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
    vectors++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h0, 32'h0050_0093}) begin
      miscompares++;
      $display("FAIL addi_latency: got we %b addr %h data %h, required 1 00000000 00500093",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    wait_empty();
  endtask

  task automatic test_r_type();
    bus.mem_ready = 1'b1;
    send(OpAdd,  5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_81B3);
    send(OpSub,  5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h4020_81B3);
    send(OpSra,  5'd4, 5'd5, 5'd6, 32'd0, 1'b1, 32'h4062_D233);
    send(OpSltu, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h0031_30B3);
    wait_empty();
  endtask

  task automatic test_sw_lui();
    bus.mem_ready = 1'b1;
    send(OpSw,   5'd0, 5'd1, 5'd2, 32'd8,       1'b1, 32'h0020_A423);
    send(OpLui,  5'd5, 5'd0, 5'd0, 32'h1_2345,  1'b1, 32'h1234_52B7);
    send(OpAddi, 5'd1, 5'd0, 5'd9, 32'd2047,    1'b1, 32'h7FF0_0093);
    send(OpAddi, 5'd2, 5'd3, 5'd0, -32'sd2048,  1'b1, 32'h8001_8113);
    wait_empty();
  endtask

  task automatic test_errors();
    bus.mem_ready = 1'b1;
    wait_empty();
    send(OpAddi, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0);
    vectors += 2;
    if (bus.err !== 1'b1) begin
      miscompares++; $display("FAIL err_addi_range: got err %b required 1", bus.err);
    end
    if (bus.count !== 3'd0) begin
      miscompares++; $display("FAIL err_count: got count %0d required 0", bus.count);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++; $display("FAIL err_pulse_width: got err %b required 0", bus.err);
    end
    send(OpRsvd, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'h0);
    vectors++;
    if (bus.err !== 1'b1) begin
      miscompares++; $display("FAIL err_reserved: got err %b required 1", bus.err);
    end
    send(OpSw, 5'd0, 5'd1, 5'd2, -32'sd2049, 1'b0, 32'h0);
    vectors++;
    if (bus.err !== 1'b1) begin
      miscompares++; $display("FAIL err_sw_range: got err %b required 1", bus.err);
    end
    wait_empty();
  endtask

  task automatic test_btype();
    bus.mem_ready = 1'b1;
    wait_empty();
`ifdef INSTR_ENC_BTYPE_EN
    send(OpBne, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 32'hFE20_9CE3);
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++; $display("FAIL bne_err: got err %b required 0", bus.err);
    end
    send(OpBeq, 5'd0, 5'd0, 5'd0, 32'd4094, 1'b1, 32'h7E00_0FE3);
    send(OpBeq, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'h0);
    vectors++;
    if (bus.err !== 1'b1) begin
      miscompares++; $display("FAIL beq_odd_err: got err %b required 1", bus.err);
    end
`else
    send(OpBne, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b0, 32'h0);
    vectors += 2;
    if (bus.err !== 1'b1) begin
      miscompares++; $display("FAIL bne_disabled_err: got err %b required 1", bus.err);
    end
    if (bus.count !== 3'd0) begin
      miscompares++; $display("FAIL bne_disabled_count: got count %0d required 0", bus.count);
    end
`endif
    wait_empty();
  endtask

  task automatic test_full();
    logic [31:0] w;
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      w = (32'(i) << 20) | (32'(i) << 7) | 32'h13;
      send(OpAddi, 5'(i), 5'd0, 5'd0, 32'(i), 1'b1, w);
    end
    vectors += 2;
    if (bus.count !== 3'(DEPTH)) begin
      miscompares++; $display("FAIL full_count: got %0d required %0d", bus.count, DEPTH);
    end
    if (bus.req_ready !== 1'b0) begin
      miscompares++; $display("FAIL full_req_ready: got %b required 0", bus.req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, sb[0]}) begin
        miscompares++;
        $display("FAIL stall_stable: got we %b addr %h data %h, required 1 %h %h",
                 bus.mem_we, bus.mem_addr, bus.mem_wdata, sb[0][63:32], sb[0][31:0]);
      end
    end
    @(posedge clk);
    #1;
    // Request offered in the cycle the stall releases must wait one cycle.
    bus.mem_ready = 1'b1;
    send(OpAddi, 5'd5, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0293);
    vectors++;
    if (bus.count !== 3'd3) begin
      miscompares++; $display("FAIL full_release_count: got %0d required 3", bus.count);
    end
    wait_empty();
  endtask

  task automatic test_back_to_back();
    bus.mem_ready = 1'b1;
    wait_empty();
    for (int i = 1; i <= 4; i++) begin
      send(OpAddi, 5'(i), 5'd0, 5'd0, 32'(i * 16), 1'b1,
           (32'(i * 16) << 20) | (32'(i) << 7) | 32'h13);
      vectors++;
      if (bus.count !== 3'd1) begin
        miscompares++; $display("FAIL b2b_count_%0d: got %0d required 1", i, bus.count);
      end
    end
    wait_empty();
  endtask

  task automatic test_reset_mid();
    wait_empty();
    bus.mem_ready = 1'b0;
    send(OpAdd, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_81B3);
    send(OpSub, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h4020_81B3);
    vectors++;
    if (bus.count !== 3'd2) begin
      miscompares++; $display("FAIL pre_reset_count: got %0d required 2", bus.count);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.count, bus.mem_we, bus.mem_addr, bus.req_ready} !== {3'd0, 1'b0, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_reset: got count %0d we %b addr %h ready %b, required 0 0 0 1",
               bus.count, bus.mem_we, bus.mem_addr, bus.req_ready);
    end
    rst = 1'b0;
    sb.delete();
    push_addr = 32'h0;
    bus.mem_ready = 1'b1;
    send(OpLui, 5'd5, 5'd0, 5'd0, 32'h1_2345, 1'b1, 32'h1234_52B7);
    wait_empty();
  endtask

  task automatic test_wrap();
    wbus.req_op    = OpAddi;
    wbus.req_rd    = 5'd1;
    wbus.req_rs1   = 5'd0;
    wbus.req_rs2   = 5'd0;
    wbus.req_imm   = 32'd5;
    wbus.req_valid = 1'b1;
    wbus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({wbus.mem_we, wbus.mem_addr, wbus.mem_wdata} !== {1'b1, 32'hFFFF_FFFC, 32'h0050_0093}) begin
      miscompares++;
      $display("FAIL wrap_first: got we %b addr %h data %h, required 1 fffffffc 00500093",
               wbus.mem_we, wbus.mem_addr, wbus.mem_wdata);
    end
    wbus.req_imm = 32'd6;
    @(posedge clk);
    #1;
    wbus.req_valid = 1'b0;
    vectors++;
    if ({wbus.mem_we, wbus.mem_addr, wbus.mem_wdata} !== {1'b1, 32'h0, 32'h0060_0093}) begin
      miscompares++;
      $display("FAIL wrap_second: got we %b addr %h data %h, required 1 00000000 00600093",
               wbus.mem_we, wbus.mem_addr, wbus.mem_wdata);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({wbus.mem_we, wbus.mem_addr} !== {1'b0, 32'h4}) begin
      miscompares++;
      $display("FAIL wrap_after: got we %b addr %h, required 0 00000004",
               wbus.mem_we, wbus.mem_addr);
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = OpAdd;
    bus.req_rd     = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.req_imm    = '0;
    bus.mem_ready  = 1'b0;
    wbus.req_valid = 1'b0;
    wbus.req_op    = OpAdd;
    wbus.req_rd    = '0;
    wbus.req_rs1   = '0;
    wbus.req_rs2   = '0;
    wbus.req_imm   = '0;
    wbus.mem_ready = 1'b0;

    test_reset();
    test_addi_latency();
    test_r_type();
    test_sw_lui();
    test_errors();
    test_btype();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_wrap();

    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL pending_writes: got %0d outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
